picobello_axi_err_responder: RTL



---
 rtl/picobello_pkg.sv | 12 +
 rtl/fifo_v3.sv | 52 +++++
 rtl/picobello_axi_err_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/picobello_pkg.sv
// picobello_pkg: AXI response codes, default error read pattern and responder FSM state types.
package picobello_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;
  localparam logic [63:0] RDATA_DEFAULT = 64'hBADC_AB1E_BADC_AB1E;
  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_BURST} r_state_e;
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: common_cells-compatible synchronous FIFO (subset of ports used here).
//   clk_i/rst_ni   clock, async active-low reset
//   flush_i        empties the FIFO
//   full_o/empty_o registered status
//   data_i/push_i  write side; push while full is ignored
//   data_o/pop_i   read side; pop while empty is ignored
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic push_ok, pop_ok;
  dtype mem_q [DEPTH];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  // In fall-through mode a push popped in the same cycle bypasses storage.
  assign push_ok = push_i & ~full_o & ~(FALL_THROUGH & empty_o & pop_i);
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
      if (pop_ok) rd_q <= (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/picobello_axi_err_responder.sv
// picobello_axi_err_responder: AXI4 subordinate answering every request with an error response.
//   AW/W/B: AW IDs buffered in a FIFO, W beats drained, one B per burst with Resp.
//   AR/R  : {id,len} buffered in a FIFO, len+1 R beats of RData with Resp.
//   Optional macro PB_ERR_RESP_LOG_EN adds log_clr_i, err_cnt_o, err_addr_o, err_seen_o.
module picobello_axi_err_responder
  import picobello_pkg::*;
#(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned MaxTxns   = 4,
  parameter logic [1:0]  Resp      = RESP_DECERR,
  parameter logic [63:0] RData     = RDATA_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o
`ifdef PB_ERR_RESP_LOG_EN
  ,
  input  logic                 log_clr_i,
  output logic [31:0]          err_cnt_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_seen_o
`endif
);
  logic aw_full, aw_empty, ar_full, ar_empty;
  logic aw_hs, ar_hs, w_pop, r_beat, r_pop;
  logic [IdWidth-1:0] aw_head, b_id_q;
  logic [IdWidth+7:0] ar_head;
  logic [7:0] cnt_q;
  w_state_e w_q, w_d;
  r_state_e r_q, r_d;
  // Readies are held low while reset is asserted and come straight from registered full.
  assign aw_ready_o = rst_ni & ~aw_full;
  assign ar_ready_o = rst_ni & ~ar_full;
  assign aw_hs = aw_valid_i & aw_ready_o;
  assign ar_hs = ar_valid_i & ar_ready_o;
  assign w_pop = w_valid_i & w_ready_o & w_last_i;
  assign r_beat = r_valid_o & r_ready_i;
  assign r_pop = r_beat & r_last_o;
  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(IdWidth), .DEPTH(MaxTxns)) i_aw_fifo (
    .clk_i, .rst_ni, .flush_i(1'b0), .full_o(aw_full), .empty_o(aw_empty),
    .data_i(aw_id_i), .push_i(aw_hs), .data_o(aw_head), .pop_i(w_pop)
  );
  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(IdWidth+8), .DEPTH(MaxTxns)) i_ar_fifo (
    .clk_i, .rst_ni, .flush_i(1'b0), .full_o(ar_full), .empty_o(ar_empty),
    .data_i({ar_id_i, ar_len_i}), .push_i(ar_hs), .data_o(ar_head), .pop_i(r_pop)
  );
  // Leaving IDLE on the push itself lets the first W/R cycle follow the address handshake directly.
  always_comb begin
    w_d = (w_q == W_IDLE)  ? ((~aw_empty | aw_hs) ? W_DRAIN : W_IDLE) :
          (w_q == W_DRAIN) ? (w_pop ? W_RESP : W_DRAIN) :
                             (b_ready_i ? W_IDLE : W_RESP);
    r_d = (r_q == R_IDLE) ? ((~ar_empty | ar_hs) ? R_BURST : R_IDLE) :
                            (r_pop ? R_IDLE : R_BURST);
  end
  assign w_ready_o = w_q == W_DRAIN;
  assign b_valid_o = w_q == W_RESP;
  assign b_id_o    = b_valid_o ? b_id_q : '0;
  assign b_resp_o  = b_valid_o ? Resp : '0;
  assign r_valid_o = r_q == R_BURST;
  assign r_id_o    = r_valid_o ? ar_head[IdWidth+7:8] : '0;
  assign r_data_o  = r_valid_o ? DataWidth'(RData) : '0;
  assign r_resp_o  = r_valid_o ? Resp : '0;
  assign r_last_o  = r_valid_o & (cnt_q == ar_head[7:0]);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_q    <= W_IDLE;
      r_q    <= R_IDLE;
      b_id_q <= '0;
      cnt_q  <= '0;
    end else begin
      w_q    <= w_d;
      r_q    <= r_d;
      b_id_q <= w_pop ? aw_head : b_id_q;
      cnt_q  <= (r_q == R_IDLE) ? '0 : r_beat ? cnt_q + 8'd1 : cnt_q;
    end
  end
`ifdef PB_ERR_RESP_LOG_EN
  logic [31:0] cnt_base;
  logic [32:0] cnt_sum;
  // A clear only removes history; handshakes in the same cycle are still recorded.
  assign cnt_base = log_clr_i ? '0 : err_cnt_o;
  assign cnt_sum  = {1'b0, cnt_base} + 33'(aw_hs) + 33'(ar_hs);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o  <= '0;
      err_addr_o <= '0;
      err_seen_o <= 1'b0;
    end else begin
      err_cnt_o  <= cnt_sum[32] ? '1 : cnt_sum[31:0];
      err_addr_o <= ar_hs ? ar_addr_i : aw_hs ? aw_addr_i : log_clr_i ? '0 : err_addr_o;
      err_seen_o <= aw_hs | ar_hs | (err_seen_o & ~log_clr_i);
    end
  end
`endif
endmodule
